// File: rtl/signed_add_sat_pipe_if.sv
// Valid/ready operand and result streams for signed_add_sat_pipe.
// The master drives operands and accepts results; the slave is the adder.
interface signed_add_sat_pipe_if #(
    parameter int WIDTH = 8
);
    logic             up_valid;
    logic             up_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sat_en;
    logic             down_valid;
    logic             down_ready;
    logic [WIDTH-1:0] sum;
    logic             overflow;

    modport master (
        output up_valid, a, b, sat_en, down_ready,
        input  up_ready, down_valid, sum, overflow
    );

    modport slave (
        input  up_valid, a, b, sat_en, down_ready,
        output up_ready, down_valid, sum, overflow
    );
endinterface

// File: rtl/signed_add_sat_pipe.sv
// Pipelined two's-complement adder with overflow detection, optional saturation,
// a globally stalled valid/ready pipeline and sticky/counted overflow statistics.
module signed_add_sat_pipe #(
    parameter int WIDTH   = 8,
    parameter int LATENCY = 2,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    signed_add_sat_pipe_if.slave bus,
    input  logic                 clr_stats,
    output logic                 sticky_ovf,
    output logic [CNT_W-1:0]     ovf_cnt
);

    localparam logic [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic             w_adv;
    logic             r_v0;
    logic             r_s0;
    logic [WIDTH-1:0] r_a0;
    logic [WIDTH-1:0] r_b0;
    logic [WIDTH-1:0] w_raw;
    logic [WIDTH-1:0] w_res;
    logic             w_ovf;
    logic             w_event;
    logic             r_sticky;
    logic [CNT_W-1:0] r_cnt;

    // Whole pipe moves together whenever the output slot is free or being drained.
    assign w_adv        = bus.down_ready | ~bus.down_valid;
    assign bus.up_ready = w_adv;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v0 <= 1'b0;
            r_s0 <= 1'b0;
            r_a0 <= '0;
            r_b0 <= '0;
        end else if (w_adv) begin
            r_v0 <= bus.up_valid;
            r_s0 <= bus.sat_en;
            r_a0 <= bus.a;
            r_b0 <= bus.b;
        end
    end

    always_comb begin
        w_raw = r_a0 + r_b0;
        w_ovf = (r_a0[WIDTH-1] == r_b0[WIDTH-1]) & (w_raw[WIDTH-1] != r_a0[WIDTH-1]);
        w_res = w_raw;
        if (r_s0 && w_ovf) begin
            w_res = r_a0[WIDTH-1] ? MOST_NEG : MOST_POS;
        end
    end

    generate
        if (LATENCY == 1) begin : g_direct
            assign bus.down_valid = r_v0;
            assign bus.sum        = w_res;
            assign bus.overflow   = w_ovf;
        end else begin : g_delay
            localparam int D = LATENCY - 1;

            logic [D-1:0]     r_v;
            logic [D-1:0]     r_ovf;
            logic [WIDTH-1:0] r_sum [D];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_v   <= '0;
                    r_ovf <= '0;
                    for (int i = 0; i < D; i++) begin
                        r_sum[i] <= '0;
                    end
                end else if (w_adv) begin
                    r_v[0]   <= r_v0;
                    r_ovf[0] <= w_ovf;
                    r_sum[0] <= w_res;
                    for (int i = 1; i < D; i++) begin
                        r_v[i]   <= r_v[i-1];
                        r_ovf[i] <= r_ovf[i-1];
                        r_sum[i] <= r_sum[i-1];
                    end
                end
            end

            assign bus.down_valid = r_v[D-1];
            assign bus.sum        = r_sum[D-1];
            assign bus.overflow   = r_ovf[D-1];
        end
    endgenerate

    assign w_event = bus.down_valid & bus.down_ready & bus.overflow;

    // An overflow delivered in the same cycle as a clear restarts the count at one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (w_event) begin
            r_sticky <= 1'b1;
            if (clr_stats) begin
                r_cnt <= CNT_W'(1);
            end else if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (clr_stats) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end
    end

    assign sticky_ovf = r_sticky;
    assign ovf_cnt    = r_cnt;

endmodule
